rand_spot_gen: RTL

- Consumes the free-running 8-bit pseudo-random byte stream from the LFSR stage, one byte per clock, with no valid signal.
- Assembles random screen spots: 10-bit x, 9-bit y and 12-bit RGB444 colour.
- Discards any spot that falls outside the active VGA area (rejection sampling).
- Hands accepted spots to the framebuffer writer over a valid/ready handshake, SPOTS_PER_FRAME spots per frame_start pulse.

---
 rtl/rand_spot_gen.sv | 121 ++++++++++++
 1 files changed

// File: rtl/rand_spot_gen.sv
// rand_spot_gen: builds random VGA spots from a free-running LFSR byte stream,
// rejecting off-screen candidates and offering accepted ones over valid/ready.
module rand_spot_gen #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned SPOTS_PER_FRAME = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rnd_in,
  input  logic        frame_start,
  output logic        spot_valid,
  input  logic        spot_ready,
  output logic [9:0]  spot_x,
  output logic [8:0]  spot_y,
  output logic [11:0] spot_rgb,
  output logic        busy,
  output logic [15:0] reject_cnt,
  output logic        frame_overrun
);
  typedef enum logic [1:0] {IDLE, GATHER, CHECK, OFFER} state_t;
  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      emitted_q, emitted_d;
  logic [4:0][7:0] b_q, b_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            ovr_q, ovr_d;
  logic [9:0]      x_q, x_d;
  logic [8:0]      y_q, y_d;
  logic [11:0]     rgb_q, rgb_d;
  logic [15:0]     rej_q, rej_d;
  logic [9:0]      cx;
  logic [8:0]      cy;
  logic [11:0]     crgb;
  logic            fits, last, unused_bits;
  // bytes shift in at the top, so after five captures b_q[0] holds the first one
  assign cx          = {b_q[1][1:0], b_q[0]};
  assign cy          = {b_q[3][0], b_q[2]};
  assign crgb        = {b_q[4], b_q[3][7:4]};
  assign unused_bits = ^b_q[3][3:1];
  assign fits        = 32'(cx) < H_ACTIVE && 32'(cy) < V_ACTIVE;
  assign last        = 32'(emitted_q) + 32'd1 == SPOTS_PER_FRAME;
  assign busy_d      = state_d != IDLE;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    emitted_d = emitted_q;
    b_d       = b_q;
    valid_d   = valid_q;
    x_d       = x_q;
    y_d       = y_q;
    rgb_d     = rgb_q;
    rej_d     = rej_q;
    ovr_d     = ovr_q | (frame_start && state_q != IDLE);
    case (state_q)
      IDLE: if (frame_start) begin
        state_d   = GATHER;
        idx_d     = '0;
        emitted_d = '0;
      end
      GATHER: begin
        b_d     = {rnd_in, b_q[4:1]};
        idx_d   = idx_q + 3'd1;
        state_d = idx_q == 3'd4 ? CHECK : GATHER;
      end
      CHECK: if (fits) begin
        x_d     = cx;
        y_d     = cy;
        rgb_d   = crgb;
        valid_d = 1'b1;
        state_d = OFFER;
      end else begin
        rej_d   = rej_q + 16'(rej_q != '1);
        idx_d   = '0;
        state_d = GATHER;
      end
      OFFER: if (spot_ready) begin
        valid_d   = 1'b0;
        emitted_d = emitted_q + 8'd1;
        idx_d     = '0;
        state_d   = last ? IDLE : GATHER;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      emitted_q <= '0;
      b_q       <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovr_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      rgb_q     <= '0;
      rej_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      emitted_q <= emitted_d;
      b_q       <= b_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovr_q     <= ovr_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rgb_q     <= rgb_d;
      rej_q     <= rej_d;
    end
  end
  assign spot_valid    = valid_q;
  assign spot_x        = x_q;
  assign spot_y        = y_q;
  assign spot_rgb      = rgb_q;
  assign busy          = busy_q;
  assign reject_cnt    = rej_q;
  assign frame_overrun = ovr_q;
endmodule
